ws2812_bus_if: RTL and testbench

//   PicoSoC iomem slave that owns the LED colour map and feeds the ws2812 serial driver.
//   - Keeps a CPU-readable shadow of raw RGB per LED.
//   - Applies a global brightness scale.
//   - Reorders each colour to GRB wire order.
//   - Issues single-cycle write pulses (led_num/led_rgb/led_write) to the driver.
//   - A brightness change automatically re-sends every LED.

---
 rtl/ws2812_bus_if_pkg.sv | 22 ++
 rtl/ws2812_bus_if_if.sv | 15 +
 rtl/ws2812_bus_if_scale.sv | 11 +
 rtl/ws2812_bus_if.sv | 148 ++++++++++++++
 tb/tb_ws2812_bus_if.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_bus_if_pkg.sv
// ws2812_bus_if_pkg: shared definitions for the ws2812 iomem slave.
//   - register word offsets (addr[10:2]), refresh FSM states, colour struct,
//     and the GRB wire-order packing helper.
package ws2812_bus_if_pkg;
   // Word indices within addr[10:2]; LED n lives at word n (bit 8 clear).
   localparam logic [8:0] BRIGHT_WIDX = 9'h100;
   localparam logic [8:0] STATUS_WIDX = 9'h101;
   localparam logic [7:0] BRIGHT_RST  = 8'hFF;

   typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

   // Same bit layout as the register: {R,G,B} in [23:0].
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   function automatic logic [23:0] grb_pack(rgb_t c);
      return {c.g, c.r, c.b};
   endfunction
endpackage

// File: rtl/ws2812_bus_if_if.sv
// ws2812_bus_if_if: PicoSoC iomem bus bundle.
//   master drives valid/wstrb/addr/wdata; slave returns ready/rdata.
interface ws2812_bus_if_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                   input  iomem_ready, iomem_rdata);
   modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                   output iomem_ready, iomem_rdata);
endinterface

// File: rtl/ws2812_bus_if_scale.sv
// ws2812_scale: combinational brightness scaler for one 8-bit channel.
//   chan_o = (chan_i * (bright_i + 1)) >> 8, so bright 0xFF is identity.
//   chan_i, bright_i in; chan_o out.
module ws2812_scale (
   input  logic [7:0] chan_i,
   input  logic [7:0] bright_i,
   output logic [7:0] chan_o
);
   // Product peaks at 255*256 = 0xFF00, so 16 bits never overflow.
   assign chan_o = 8'((16'(chan_i) * (16'(bright_i) + 16'd1)) >> 8);
endmodule

// File: rtl/ws2812_bus_if.sv
// ws2812_bus_if: iomem slave owning the LED colour map for the ws2812 driver.
//   clk, reset (sync, active-high); bus: iomem slave modport;
//   led_num/led_rgb/led_write: single-cycle scaled GRB write pulses to driver.
//   Bus LED writes and brightness refresh sweeps share a 2-stage pipe:
//   p1 holds {idx, raw RGB}, p2 (output flops) holds the scaled GRB word.
module ws2812_bus_if
   import ws2812_bus_if_pkg::*;
#(
   parameter int NUM_LEDS = 8
) (
   input  logic         clk,
   input  logic         reset,
   ws2812_bus_if_if.slave bus,
   output logic [7:0]   led_num,
   output logic [23:0]  led_rgb,
   output logic         led_write
);
   localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
   rgb_t             shadow_q [NUM_LEDS];
   rgb_t             shadow_d [NUM_LEDS];
   logic [7:0]       bright_q, bright_d;
   logic             ready_q, ready_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [2:1]       vld_pipe_q, vld_pipe_d;   // [1]=p1 valid, [2]=p2 valid (led_write)
   logic [7:0]       p1_idx_q, p1_idx_d;
   rgb_t             p1_rgb_q, p1_rgb_d;
   logic [7:0]       led_num_q, led_num_d;
   logic [23:0]      led_rgb_q, led_rgb_d;

   // Address decode and handshake qualification
   logic [8:0]       widx;
   logic [IDX_W-1:0] led_idx;
   logic             is_led, is_wr, busy, acc;
   logic [23:0]      cur_rgb, merged_rgb;

   assign widx    = bus.iomem_addr[10:2];
   assign led_idx = widx[IDX_W-1:0];
   assign is_led  = !widx[8] && ({1'b0, widx[7:0]} < 9'(NUM_LEDS));
   assign is_wr   = |bus.iomem_wstrb;
   assign busy    = (state_q == ST_SWEEP) || (|vld_pipe_q);
   // Reads go through while busy; writes wait so a sweep never races a bus write.
   assign acc     = bus.iomem_valid && !ready_q && !(is_wr && busy);
   assign cur_rgb = shadow_q[led_idx];

   always_comb begin
      merged_rgb = cur_rgb;
      for (int k = 0; k < 3; k++)
         if (bus.iomem_wstrb[k]) merged_rgb[8*k +: 8] = bus.iomem_wdata[8*k +: 8];
   end

   logic unused_ok;
   assign unused_ok = ^{bus.iomem_addr[31:11], bus.iomem_addr[1:0], bus.iomem_wdata[31:24]};

   // p2 scaling, one scaler per channel; bright_q is already the post-write value
   logic [2:0][7:0] raw_ch, scl_ch;
   assign raw_ch = p1_rgb_q;
   for (genvar c = 0; c < 3; c++) begin : g_scale
      ws2812_scale u_scale (.chan_i(raw_ch[c]), .bright_i(bright_q), .chan_o(scl_ch[c]));
   end

   always_comb begin
      state_d     = state_q;
      sweep_idx_d = sweep_idx_q;
      shadow_d    = shadow_q;
      bright_d    = bright_q;
      ready_d     = acc;
      rdata_d     = '0;
      vld_pipe_d  = {vld_pipe_q[1], 1'b0};
      p1_idx_d    = p1_idx_q;
      p1_rgb_d    = p1_rgb_q;
      led_num_d   = led_num_q;
      led_rgb_d   = led_rgb_q;

      if (vld_pipe_q[1]) begin
         led_num_d = p1_idx_q;
         led_rgb_d = grb_pack(rgb_t'(scl_ch));
      end

      // Sweep feeds idx 1..N-1; idx 0 was loaded by the BRIGHT write itself so
      // pulses start two cycles after that write is accepted.
      if (state_q == ST_SWEEP) begin
         vld_pipe_d[1] = 1'b1;
         p1_idx_d      = 8'(sweep_idx_q);
         p1_rgb_d      = shadow_q[sweep_idx_q];
         sweep_idx_d   = sweep_idx_q + IDX_W'(1);
         if (sweep_idx_q == IDX_W'(NUM_LEDS - 1)) state_d = ST_IDLE;
      end

      if (acc) begin
         if (is_wr) begin
            if (is_led) begin
               shadow_d[led_idx] = rgb_t'(merged_rgb);
               vld_pipe_d[1]     = 1'b1;
               p1_idx_d          = widx[7:0];
               p1_rgb_d          = rgb_t'(merged_rgb);
            end else if (widx == BRIGHT_WIDX) begin
               if (bus.iomem_wstrb[0]) bright_d = bus.iomem_wdata[7:0];
               vld_pipe_d[1] = 1'b1;
               p1_idx_d      = 8'd0;
               p1_rgb_d      = shadow_q[0];
               sweep_idx_d   = IDX_W'(1);
               state_d       = (NUM_LEDS > 1) ? ST_SWEEP : ST_IDLE;
            end
         end else begin
            if (is_led)                    rdata_d = {8'h0, cur_rgb};
            else if (widx == BRIGHT_WIDX)  rdata_d = {24'h0, bright_q};
            else if (widx == STATUS_WIDX)  rdata_d = {31'h0, busy};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sweep_idx_q <= '0;
         shadow_q    <= '{default: '0};
         bright_q    <= BRIGHT_RST;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         vld_pipe_q  <= '0;
         p1_idx_q    <= '0;
         p1_rgb_q    <= '0;
         led_num_q   <= '0;
         led_rgb_q   <= '0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
         shadow_q    <= shadow_d;
         bright_q    <= bright_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         vld_pipe_q  <= vld_pipe_d;
         p1_idx_q    <= p1_idx_d;
         p1_rgb_q    <= p1_rgb_d;
         led_num_q   <= led_num_d;
         led_rgb_q   <= led_rgb_d;
      end
   end

   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;
   assign led_write       = vld_pipe_q[2];
   assign led_num         = led_num_q;
   assign led_rgb         = led_rgb_q;
endmodule

// File: tb/tb_ws2812_bus_if.sv
// tb_ws2812_bus_if: scoreboard bench for ws2812_bus_if.
//   Driver issues bus accesses and pushes expected read data / LED pulses
//   (with expected cycle) from a register-level model; an independent monitor
//   pops and compares whenever ready or led_write is seen.
module tb_ws2812_bus_if;
   localparam int N = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  led_num;
   logic [23:0] led_rgb;
   logic        led_write;

   ws2812_bus_if_if bus ();

   ws2812_bus_if #(.NUM_LEDS(N)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .led_num(led_num), .led_rgb(led_rgb), .led_write(led_write)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state
   logic [23:0] m_led [N];
   logic [7:0]  m_bright;
   int          last_led;          // last cycle the model expects led_write high
   int          vectors = 0;
   int          fails = 0;

   typedef struct { bit chk; logic [31:0] val; } rd_t;
   typedef struct { int cyc; logic [7:0] num; logic [23:0] rgb; } led_t;
   rd_t  rq[$];
   led_t lq[$];

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Brightness scale then GRB reorder, from the register-level rules.
   function automatic logic [23:0] exp_wire(logic [23:0] raw, logic [7:0] b);
      int r, g, bl;
      r  = (int'(raw[23:16]) * (int'(b) + 1)) / 256;
      g  = (int'(raw[15:8])  * (int'(b) + 1)) / 256;
      bl = (int'(raw[7:0])   * (int'(b) + 1)) / 256;
      return {8'(g), 8'(r), 8'(bl)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_led[i] = '0;
      m_bright = 8'hFF;
      last_led = -10;
   endtask

   // Called at posedge+1; returns at posedge+1 one idle cycle after ready.
   task automatic access(input logic [3:0] ws, input logic [31:0] addr, input logic [31:0] wd);
      int          issue, exp_acc, t, n;
      bit          busy_m, is_led;
      logic [8:0]  w;
      logic [31:0] exp;
      issue  = cyc;
      w      = addr[10:2];
      n      = int'(w[7:0]);
      is_led = !w[8] && (n < N);
      busy_m = (issue <= last_led);
      exp_acc = (ws != 0 && busy_m) ? last_led + 1 : issue;
      if (ws == 0) begin
         exp = 32'h0;
         if (is_led)             exp = {8'h0, m_led[n]};
         else if (w == 9'h100)   exp = {24'h0, m_bright};
         else if (w == 9'h101)   exp = {31'h0, busy_m};
         rq.push_back('{chk: 1'b1, val: exp});
      end else
         rq.push_back('{chk: 1'b0, val: 32'h0});
      bus.iomem_valid = 1'b1;
      bus.iomem_wstrb = ws;
      bus.iomem_addr  = addr;
      bus.iomem_wdata = wd;
      t = 0;
      @(posedge clk); #1;
      while (!bus.iomem_ready && t < 200) begin @(posedge clk); #1; t++; end
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'h0;
      if (!bus.iomem_ready) begin
         check("ack_timeout", 32'(t), 32'(0));
         return;
      end
      check("accept_cycle", 32'(cyc - 1), 32'(exp_acc));
      if (ws != 0) begin
         if (is_led) begin
            for (int k = 0; k < 3; k++)
               if (ws[k]) m_led[n][8*k +: 8] = wd[8*k +: 8];
            lq.push_back('{cyc: cyc + 1, num: 8'(n), rgb: exp_wire(m_led[n], m_bright)});
            last_led = cyc + 1;
         end else if (w == 9'h100) begin
            if (ws[0]) m_bright = wd[7:0];
            for (int i = 0; i < N; i++)
               lq.push_back('{cyc: cyc + 1 + i, num: 8'(i), rgb: exp_wire(m_led[i], m_bright)});
            last_led = cyc + N;
         end
      end
      @(posedge clk); #1;
   endtask

   // Monitor
   logic prev_ready = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.iomem_ready) begin
            check("ready_single", 32'(prev_ready), 32'(0));
            if (rq.size() == 0) check("unexpected_ready", 32'(1), 32'(0));
            else begin
               rd_t e;
               e = rq.pop_front();
               if (e.chk) check("rdata", bus.iomem_rdata, e.val);
            end
         end
         if (led_write) begin
            if (lq.size() == 0) check("unexpected_led_write", {24'h0, led_num}, 32'hFFFF_FFFF);
            else begin
               led_t e;
               e = lq.pop_front();
               check("led_cycle", 32'(cyc), 32'(e.cyc));
               check("led_num", {24'h0, led_num}, {24'h0, e.num});
               check("led_rgb", {8'h0, led_rgb}, {8'h0, e.rgb});
            end
         end
      end
      prev_ready = reset ? 1'b0 : bus.iomem_ready;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] r;
      int op, n;
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'h0;
      bus.iomem_addr  = '0;
      bus.iomem_wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",     {31'h0, bus.iomem_ready}, 32'h0);
      check("rst_rdata",     bus.iomem_rdata, 32'h0);
      check("rst_led_write", {31'h0, led_write}, 32'h0);
      check("rst_led_num",   {24'h0, led_num}, 32'h0);
      check("rst_led_rgb",   {8'h0, led_rgb}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // 1. reset readback
      access(4'h0, 32'h400, 0);
      access(4'h0, 32'h404, 0);
      access(4'h0, 32'h000, 0);
      // 2/3. full and partial LED writes
      access(4'hF, 32'h008, 32'h0011_2233);
      access(4'h0, 32'h008, 0);
      access(4'h2, 32'h008, 32'h0000_AA00);
      access(4'h0, 32'h008, 0);
      // 4. brightness sweep, status read and stalled write during sweep
      access(4'hF, 32'h000, 32'h00FF_8040);
      access(4'hF, 32'h400, 32'h0000_007F);
      access(4'h0, 32'h404, 0);
      access(4'hF, 32'h00C, 32'h8844_2211);
      access(4'hF, 32'h400, 32'h0000_007F);
      // 5. out-of-range and unmapped
      access(4'hF, 32'h020, 32'h00AB_CDEF);
      access(4'h0, 32'h020, 0);
      access(4'hF, 32'h500, 32'h1234_5678);
      access(4'h0, 32'h500, 0);
      access(4'hF, 32'h404, 32'h1);

      // Random traffic
      for (int i = 0; i < 80; i++) begin
         r  = $urandom();
         op = int'($urandom_range(0, 9));
         n  = int'($urandom_range(0, N + 1));
         if (op <= 4)      access(4'($urandom_range(1, 15)), {r[31:11], 9'(n), r[1:0]}, $urandom());
         else if (op <= 6) access(4'h0, {r[31:11], 9'(n), r[1:0]}, 0);
         else if (op == 7) access(4'hF, 32'h400, $urandom());
         else if (op == 8) access(4'h0, (r[0] ? 32'h404 : 32'h400), 0);
         else              access(4'($urandom_range(0, 15)), 32'h500 + {r[7:0], 2'b00}, $urandom());
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      // 6. reset mid-sweep
      access(4'hF, 32'h000, 32'h0012_3456);
      access(4'hF, 32'h400, 32'h0000_0040);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      lq.delete();
      rq.delete();
      model_reset();
      check("rst2_ready",     {31'h0, bus.iomem_ready}, 32'h0);
      check("rst2_led_write", {31'h0, led_write}, 32'h0);
      check("rst2_led_num",   {24'h0, led_num}, 32'h0);
      check("rst2_led_rgb",   {8'h0, led_rgb}, 32'h0);
      repeat (12) begin @(posedge clk); #1; end
      access(4'h0, 32'h400, 0);
      access(4'h0, 32'h000, 0);
      access(4'h0, 32'h404, 0);

      repeat (20) begin @(posedge clk); #1; end
      check("led_queue_drained", 32'(lq.size()), 32'(0));
      check("rd_queue_drained",  32'(rq.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
